// File: rtl/uart_rx_front.sv
// Oversampled UART receiver front end: start detection, 3-point majority sampling,
// optional parity check and a single-cycle result strobe per frame.
module uart_rx_front #(
    parameter int width = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             RX_IN,
    input  logic [5:0]       Prescale,
    input  logic             PAR_EN,
    input  logic             PAR_TYP,
    output logic [width-1:0] Rx_P_Data,
    output logic             RxValid,
    output logic             Parity_Error,
    output logic             Stop_Error
);

    localparam int BW = (width > 1) ? $clog2(width) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(width - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t           state, state_nxt;
    logic [5:0]       edge_cnt;
    logic [BW-1:0]    bit_cnt;
    logic [5:0]       psc;
    logic             par_en_q;
    logic             par_typ_q;
    logic [2:0]       samples;
    logic [width-1:0] shift;
    logic             par_err;

    logic [5:0] psc_dec;
    logic [5:0] half;
    logic       last_edge;
    logic       maj;

    always_comb begin
        case (Prescale)
            6'd16:   psc_dec = 6'd16;
            6'd32:   psc_dec = 6'd32;
            default: psc_dec = 6'd8;
        endcase
    end

    assign half      = {1'b0, psc[5:1]};
    assign last_edge = (edge_cnt == psc - 6'd1);
    assign maj       = (samples[0] & samples[1]) | (samples[0] & samples[2]) |
                       (samples[1] & samples[2]);

    always_ff @(posedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (!RX_IN) state_nxt = START;
            START:   if (last_edge) state_nxt = maj ? IDLE : DATA;
            DATA:    if (last_edge && bit_cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
            PARITY:  if (last_edge) state_nxt = STOP;
            STOP:    if (last_edge) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The IDLE cycle that sees the line low is already edge 0 of the start bit.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            edge_cnt  <= '0;
            bit_cnt   <= '0;
            psc       <= 6'd8;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_err   <= 1'b0;
        end else if (state == IDLE) begin
            edge_cnt <= RX_IN ? 6'd0 : 6'd1;
            if (!RX_IN) begin
                bit_cnt   <= '0;
                psc       <= psc_dec;
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
                par_err   <= 1'b0;
            end
        end else begin
            edge_cnt <= last_edge ? 6'd0 : edge_cnt + 6'd1;
            if (state == DATA && last_edge)
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
            if (state == PARITY && last_edge)
                par_err <= maj ^ (^shift) ^ par_typ_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            samples <= '0;
            shift   <= '0;
        end else if (state != IDLE) begin
            if (edge_cnt == half - 6'd1) samples[0] <= RX_IN;
            if (edge_cnt == half)        samples[1] <= RX_IN;
            if (edge_cnt == half + 6'd1) samples[2] <= RX_IN;
            if (state == DATA && last_edge)
                shift[bit_cnt] <= maj;
        end
    end

    // Result strobes land in the IDLE cycle that follows the stop bit.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            Rx_P_Data    <= '0;
            RxValid      <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
        end else begin
            RxValid      <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
            if (state == STOP && last_edge) begin
                Parity_Error <= par_err;
                Stop_Error   <= ~maj;
                if (!par_err && maj) begin
                    RxValid   <= 1'b1;
                    Rx_P_Data <= shift;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_front.sv
// Directed bench for uart_rx_front: table of frames plus hand-built corner sequences.
module tb_uart_rx_front;

    logic       CLK = 1'b0;
    logic       Reset;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] Rx_P_Data;
    logic       RxValid;
    logic       Parity_Error;
    logic       Stop_Error;

    uart_rx_front #(.width(8)) dut (
        .CLK(CLK), .Reset(Reset), .RX_IN(RX_IN), .Prescale(Prescale),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .Rx_P_Data(Rx_P_Data),
        .RxValid(RxValid), .Parity_Error(Parity_Error), .Stop_Error(Stop_Error)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int         cyc;
        logic       v;
        logic       pe;
        logic       se;
        logic [7:0] d;
    } ev_t;

    typedef struct {
        logic [5:0] psc;
        int         dp;
        logic       pen;
        logic       pt;
        logic [7:0] d;
        logic       pb;
        logic       sb;
        logic       ev;
        logic       epe;
        logic       ese;
        logic [7:0] ed;
        int         lat;
    } vec_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   t0_last;
    ev_t  ev_q[$];
    vec_t vt[8];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK)
        if (RxValid || Parity_Error || Stop_Error)
            ev_q.push_back('{cyc, RxValid, Parity_Error, Stop_Error, Rx_P_Data});

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge CLK);
            RX_IN = 1'b1;
        end
    endtask

    // Drives one frame; the first negedge drive is the start-detect cycle.
    task automatic send_frame(input logic [5:0] psc, input int dp, input logic pen,
                              input logic pt, input logic [7:0] d, input logic pb,
                              input logic sb);
        logic bits[12];
        int   nb;
        bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) bits[k+1] = d[k];
        nb = 9;
        if (pen) begin
            bits[nb] = pb;
            nb++;
        end
        bits[nb] = sb;
        nb++;
        for (int b = 0; b < nb; b++) begin
            for (int e = 0; e < dp; e++) begin
                @(negedge CLK);
                if (b == 0 && e == 0) begin
                    Prescale = psc;
                    PAR_EN   = pen;
                    PAR_TYP  = pt;
                    t0_last  = cyc;
                end
                RX_IN = bits[b];
            end
        end
    endtask

    initial begin
        int t0a;
        //          psc    dp  pen   pt    data   pb    sb    ev    epe   ese   ed     lat
        vt[0] = '{6'd8,   8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hA5, 80};
        vt[1] = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h3C, 176};
        vt[2] = '{6'd16, 16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 176};
        vt[3] = '{6'd32, 32, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 352};
        vt[4] = '{6'd8,   8, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h01, 88};
        vt[5] = '{6'd5,   8, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'hC3, 80};
        vt[6] = '{6'd32, 32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h81, 320};
        vt[7] = '{6'd8,   8, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 88};

        Reset = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
        repeat (3) @(negedge CLK);
        chk("reset_data",  int'(Rx_P_Data),    0);
        chk("reset_valid", int'(RxValid),      0);
        chk("reset_perr",  int'(Parity_Error), 0);
        chk("reset_serr",  int'(Stop_Error),   0);
        Reset = 1'b0;
        idle(4);

        for (int i = 0; i < 8; i++) begin
            ev_q.delete();
            send_frame(vt[i].psc, vt[i].dp, vt[i].pen, vt[i].pt, vt[i].d, vt[i].pb, vt[i].sb);
            idle(10);
            chk($sformatf("v%0d_events", i), ev_q.size(), 1);
            if (ev_q.size() == 1) begin
                chk($sformatf("v%0d_latency", i), ev_q[0].cyc - t0_last, vt[i].lat);
                chk($sformatf("v%0d_valid", i), int'(ev_q[0].v), int'(vt[i].ev));
                chk($sformatf("v%0d_perr", i), int'(ev_q[0].pe), int'(vt[i].epe));
                chk($sformatf("v%0d_serr", i), int'(ev_q[0].se), int'(vt[i].ese));
            end
            chk($sformatf("v%0d_data", i), int'(Rx_P_Data), int'(vt[i].ed));
        end

        // 3-cycle low glitch must be rejected, then a clean frame still lands.
        ev_q.delete();
        Prescale = 6'd8; PAR_EN = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            RX_IN = 1'b0;
        end
        idle(20);
        chk("glitch_events", ev_q.size(), 0);
        send_frame(6'd8, 8, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1);
        idle(10);
        chk("glitch_next_events", ev_q.size(), 1);
        chk("glitch_next_data", int'(Rx_P_Data), 'h55);

        // Back-to-back frames with no idle gap.
        ev_q.delete();
        send_frame(6'd8, 8, 1'b0, 1'b0, 8'h12, 1'b0, 1'b1);
        t0a = t0_last;
        send_frame(6'd8, 8, 1'b0, 1'b0, 8'h34, 1'b0, 1'b1);
        idle(10);
        chk("b2b_events", ev_q.size(), 2);
        if (ev_q.size() == 2) begin
            chk("b2b_first_lat", ev_q[0].cyc - t0a, 80);
            chk("b2b_first_data", int'(ev_q[0].d), 'h12);
            chk("b2b_spacing", ev_q[1].cyc - ev_q[0].cyc, 80);
            chk("b2b_second_data", int'(ev_q[1].d), 'h34);
        end

        // Config changes mid-frame must be ignored.
        ev_q.delete();
        fork
            send_frame(6'd8, 8, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
            begin
                repeat (20) @(negedge CLK);
                Prescale = 6'd16; PAR_EN = 1'b1;
            end
        join
        idle(10);
        chk("cfg_hold_events", ev_q.size(), 1);
        if (ev_q.size() == 1) chk("cfg_hold_latency", ev_q[0].cyc - t0_last, 80);
        chk("cfg_hold_data", int'(Rx_P_Data), 'h96);

        // Break: line held low for three frame times.
        ev_q.delete();
        Prescale = 6'd8; PAR_EN = 1'b0;
        repeat (240) begin
            @(negedge CLK);
            if (ev_q.size() == 0 && RX_IN) t0a = cyc;
            RX_IN = 1'b0;
        end
        idle(20);
        chk("break_events", ev_q.size(), 3);
        if (ev_q.size() == 3) begin
            chk("break_first_lat", ev_q[0].cyc - t0a, 80);
            chk("break_spacing", ev_q[2].cyc - ev_q[1].cyc, 80);
            chk("break_serr", int'(ev_q[0].se & ev_q[1].se & ev_q[2].se), 1);
            chk("break_valid", int'(ev_q[0].v | ev_q[1].v | ev_q[2].v), 0);
        end
        chk("break_data", int'(Rx_P_Data), 'h96);

        // Reset during data bit 4 drops the frame and clears the outputs.
        ev_q.delete();
        fork
            send_frame(6'd8, 8, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1);
            begin
                repeat (44) @(negedge CLK);
                Reset = 1'b1;
                @(negedge CLK);
                chk("midreset_data", int'(Rx_P_Data), 0);
                chk("midreset_strobes", int'({RxValid, Parity_Error, Stop_Error}), 0);
                Reset = 1'b0;
            end
        join
        idle(20);
        chk("midreset_events", ev_q.size(), 0);
        send_frame(6'd8, 8, 1'b0, 1'b0, 8'hF0, 1'b0, 1'b1);
        idle(10);
        chk("after_reset_events", ev_q.size(), 1);
        if (ev_q.size() == 1) chk("after_reset_latency", ev_q[0].cyc - t0_last, 80);
        chk("after_reset_data", int'(Rx_P_Data), 'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
